// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared constants and queue entry layout for the instruction fetch front end.
package fetch_prefetch_unit_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] FOUR             = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetch queue slot: fetched instruction and the address following it.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus_4;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction memory request/response channel between fetch (master) and imem (slave).
interface fetch_prefetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_prefetch_unit_fifo.sv
// Synchronous in-order FIFO with registered storage, no bypass, and a clear that wins over push/pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         clear,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: slots are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the PC, issues credit-checked imem requests and presents the prefetch queue head to IF/ID.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
  input  logic                         clk,
  input  logic                         rst,
  fetch_prefetch_unit_if.master        imem,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         stall,
  output logic                         if_valid,
  output logic [31:0]                  if_instruction,
  output logic [31:0]                  if_pc_plus_4,
  output logic [3:0]                   if_pc_page
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [31:0]   head_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic          fetch_en;
  logic [CW-1:0] count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          resp;
  logic          keep;
  logic          issue;
  logic          pop;
  logic          credit_ok;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Credit check counts in-flight requests against free queue slots; same-cycle pops are not credited.
  always_comb begin
    resp           = imem.imem_rvalid && (outstanding != '0);
    credit_ok      = (SW'(count) + SW'(outstanding)) < SW'(DEPTH);
    imem.imem_req  = fetch_en && !redirect && (outstanding < OW'(MAX_OUTSTANDING)) && credit_ok;
    issue          = imem.imem_req && imem.imem_gnt;
    keep           = resp && !redirect && (drop_cnt == '0);
    pop            = !fifo_empty && !stall && !redirect;
    target_pc      = {redirect_pc[31:2], 2'b00};
    push_entry     = '{instr: imem.imem_rdata, pc_plus_4: resp_pc + FOUR};
  end

  assign imem.imem_addr = pc;

  // resp_pc tracks the address of the next response that will be kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_en    <= 1'b0;
    end else begin
      fetch_en <= 1'b1;
      if (redirect) begin
        pc          <= target_pc;
        resp_pc     <= target_pc;
        outstanding <= outstanding - OW'(resp);
        drop_cnt    <= outstanding - OW'(resp);
      end else begin
        if (issue) pc <= pc + FOUR;
        if (keep)  resp_pc <= resp_pc + FOUR;
        outstanding <= outstanding + OW'(issue) - OW'(resp);
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (keep && !fifo_full),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count),
    .head      (head)
  );

  always_comb begin
    head_pc        = head.pc_plus_4 - FOUR;
    if_valid       = !fifo_empty;
    if_instruction = if_valid ? head.instr : NOP;
    if_pc_plus_4   = if_valid ? head.pc_plus_4 : 32'h0;
    if_pc_page     = if_valid ? head_pc[31:28] : 4'h0;
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit with an epoch-style in-flight model and a latency-programmable memory.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned MAX_OUT = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc_plus_4;
  logic [3:0]  if_pc_page;

  fetch_prefetch_unit_if bus ();

  fetch_prefetch_unit #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT),
    .RESET_PC        (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (bus.master),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc_plus_4   (if_pc_plus_4),
    .if_pc_page     (if_pc_page)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { logic [31:0] instr; logic [31:0] pcp4; } ent_t;

  mreq_t       memq[$];   // requests the memory owes, in issue order
  ent_t        fq[$];     // expected prefetch queue contents
  logic [31:0] m_pc;
  bit          started;
  int          orphans;
  int          cyc;
  int          lat;
  int          n_tests;
  int          n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ei = 32'h0;
    logic [31:0] ep = 32'h0;
    logic [31:0] ea;
    logic [3:0]  pg = 4'h0;
    bit          v  = (fq.size() > 0);
    if (v) begin
      ei = fq[0].instr;
      ep = fq[0].pcp4;
      ea = ep - 32'd4;
      pg = ea[31:28];
    end
    check_eq("if_valid", 32'(if_valid), 32'(v));
    check_eq("if_instruction", if_instruction, ei);
    check_eq("if_pc_plus_4", if_pc_plus_4, ep);
    check_eq("if_pc_page", 32'(if_pc_page), 32'(pg));
  endtask

  task automatic check_reset_vals();
    check_eq("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_imem_addr", bus.imem_addr, RST_PC);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_instruction", if_instruction, 32'h0);
    check_eq("rst_if_pc_plus_4", if_pc_plus_4, 32'h0);
    check_eq("rst_if_pc_page", 32'(if_pc_page), 32'd0);
  endtask

  // One clock cycle: check IF outputs, drive inputs and memory, check the request, advance the model.
  task automatic step(input bit redir, input logic [31:0] rpc, input bit stl, input bit g);
    bit    rv = 1'b0;
    bit    orphan = 1'b0;
    bit    exp_req;
    bit    issue;
    mreq_t r;
    @(negedge clk);
    check_outputs();
    redirect    = redir;
    redirect_pc = rpc;
    stall       = stl;
    bus.imem_gnt   = g;
    bus.imem_rdata = 32'h0;
    if (orphans > 0) begin
      rv = 1'b1;
      orphan = 1'b1;
      orphans--;
      bus.imem_gnt   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      rv = 1'b1;
      bus.imem_rdata = mem_word(memq[0].addr);
    end
    bus.imem_rvalid = rv;
    #1;
    exp_req = started && !redir && (memq.size() < MAX_OUT) && (fq.size() + memq.size() < DEPTH);
    check_eq("imem_req", 32'(bus.imem_req), 32'(exp_req));
    check_eq("imem_addr", bus.imem_addr, m_pc);
    issue = exp_req && bus.imem_gnt;
    if (rv && !orphan) r = memq.pop_front();
    if (redir) begin
      fq.delete();
      foreach (memq[i]) memq[i].stale = 1'b1;
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (!stl && fq.size() > 0) void'(fq.pop_front());
      if (rv && !orphan && !r.stale) fq.push_back('{mem_word(r.addr), r.addr + 32'd4});
    end
    if (issue) begin
      memq.push_back('{m_pc, cyc + lat, 1'b0});
      m_pc = m_pc + 32'd4;
    end
    started = 1'b1;
    @(posedge clk);
    cyc++;
  endtask

  // Asynchronous reset pulse mid-stream; whatever the memory still owes becomes orphaned.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    redirect = 1'b0;
    stall = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    check_reset_vals();
    fq.delete();
    orphans = memq.size();
    memq.delete();
    m_pc = RST_PC;
    started = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    stall = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    n_tests = 0;
    n_fail = 0;
    cyc = 0;
    lat = 1;
    orphans = 0;
    started = 1'b0;
    m_pc = RST_PC;
    #2 rst = 1'b0;
    #10;
    check_reset_vals();
    @(posedge clk);
    #1 rst = 1'b1;

    // Zero-wait streaming from reset.
    repeat (40) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Stall long enough to fill the queue, then drain.
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    repeat (12) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Latency 3 memory bounded by the outstanding limit.
    lat = 3;
    repeat (30) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect with two requests in flight and no response in that cycle.
    n = 0;
    while (!(memq.size() == 2 && memq[0].due > cyc) && n < 20) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    if (n >= 20) check_eq("redir2_wait_timeout", 32'd0, 32'd1);
    step(1'b1, 32'h0000_0100, 1'b0, 1'b1);
    n = 0;
    #1;
    while (!if_valid && n < 20) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      #1;
      n++;
    end
    check_eq("redir_first_instr", if_instruction, mem_word(32'h0000_0100));
    check_eq("redir_first_pc4", if_pc_plus_4, 32'h0000_0104);
    check_eq("redir_first_page", 32'(if_pc_page), 32'd0);
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect coinciding with a response.
    lat = 1;
    n = 0;
    while (!(memq.size() > 0 && memq[0].due <= cyc) && n < 20) begin
      step(1'b0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    if (n >= 20) check_eq("redir_rv_wait_timeout", 32'd0, 32'd1);
    step(1'b1, 32'h0000_0200, 1'b0, 1'b1);
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Back-to-back redirects, then redirect during stall with a full queue.
    step(1'b1, 32'h0000_0300, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0403, 1'b0, 1'b1);
    repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset with exactly one request outstanding; its late response must be ignored.
    lat = 3;
    repeat (8) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    do_reset();
    lat = 1;
    repeat (20) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Fully randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      bit          rd;
      logic [31:0] tgt;
      if (i % 50 == 0) lat = int'($urandom_range(1, 3));
      rd  = ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF4 : $urandom;
      step(rd, tgt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
